// File: rtl/rr_arbiter_4_pkg.sv
// Shared types and the winner-selection helper for the 4-way round-robin arbiter.
package rr_arbiter_4_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef logic [IDX_W-1:0] idx_t;

  // Rotate the request vector so ptr sits at bit 0, take the lowest set bit,
  // then rotate the found position back into absolute requester numbering.
  function automatic idx_t pick_winner(input logic [N_REQ-1:0] req, input idx_t ptr);
    logic [N_REQ-1:0] rot;
    idx_t             found;
    rot   = '0;
    found = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rot[i] = req[ptr + idx_t'(i)];
    end
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) found = idx_t'(i);
    end
    return ptr + found;
  endfunction

endpackage

// File: rtl/rr_arbiter_4_decoder.sv
// 2-to-4 one-hot decoder with enable; purely combinational.
module decoder_2_4_df (
  input  logic [1:0] I,
  input  logic       En,
  output logic [3:0] Y
);

  assign Y = En ? (4'b0001 << I) : 4'b0000;

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with grant locking and an optional hold limit.
// state | meaning
// IDLE  | no owner; arbitrate among req starting at ptr
// GRANT | gnt_idx owns the resource until it drops req or hits MAX_HOLD
module rr_arbiter_4
  import rr_arbiter_4_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state, state_nxt;
  idx_t       ptr, ptr_nxt;
  idx_t       idx_nxt;
  logic [7:0] hold_cnt, hold_nxt;
  logic       release_now;
  logic       at_limit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      gnt_idx  <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      gnt_idx  <= idx_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  assign at_limit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    idx_nxt     = gnt_idx;
    hold_nxt    = hold_cnt;
    release_now = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          idx_nxt   = pick_winner(req, ptr);
          hold_nxt  = '0;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        release_now = !req[gnt_idx] || at_limit;
        if (release_now) begin
          state_nxt = IDLE;
          ptr_nxt   = gnt_idx + idx_t'(1);
        end else if (MAX_HOLD != 0) begin
          // hold_cnt stays at zero when the hold limit is disabled
          hold_nxt = hold_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign gnt_valid = (state == GRANT);

  decoder_2_4_df u_dec (
    .I  (gnt_idx),
    .En (gnt_valid),
    .Y  (gnt)
  );

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench: one arbiter with MAX_HOLD=4 and one with MAX_HOLD=0 against a queue-free behavioural model.
module tb_rr_arbiter_4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req_h4 = '0, req_h0 = '0;
  logic [3:0] gnt_h4, gnt_h0;
  logic [1:0] gnt_idx_h4, gnt_idx_h0;
  logic       gnt_valid_h4, gnt_valid_h0;

  int n_pass = 0;
  int n_total = 0;

  int m_owner [2];
  int m_ptr   [2];
  int m_run   [2];
  int m_last  [2];
  int m_lim   [2] = '{4, 0};

  always #5 clk = ~clk;

  rr_arbiter_4 #(.MAX_HOLD(4)) dut_h4 (
    .clk(clk), .rst_n(rst_n), .req(req_h4),
    .gnt(gnt_h4), .gnt_idx(gnt_idx_h4), .gnt_valid(gnt_valid_h4)
  );

  rr_arbiter_4 #(.MAX_HOLD(0)) dut_h0 (
    .clk(clk), .rst_n(rst_n), .req(req_h0),
    .gnt(gnt_h0), .gnt_idx(gnt_idx_h0), .gnt_valid(gnt_valid_h0)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %b expected %b", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_owner[u] = -1;
      m_ptr[u]   = 0;
      m_run[u]   = 0;
      m_last[u]  = 0;
    end
  endtask

  // Owner -1 means idle; m_run counts cycles the current owner has held the grant.
  task automatic model_step(input int u, input logic [3:0] r);
    if (m_owner[u] < 0) begin
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m_ptr[u] + k) % 4;
        if (m_owner[u] < 0 && r[c]) begin
          m_owner[u] = c;
          m_last[u]  = c;
          m_run[u]   = 1;
        end
      end
    end else if (!r[m_owner[u]] || (m_lim[u] != 0 && m_run[u] == m_lim[u])) begin
      m_ptr[u]   = (m_owner[u] + 1) % 4;
      m_owner[u] = -1;
    end else begin
      m_run[u]++;
    end
  endtask

  function automatic logic [3:0] exp_gnt(input int u);
    return (m_owner[u] < 0) ? 4'b0000 : (4'b0001 << m_owner[u]);
  endfunction

  task automatic check_both();
    chk("h4_gnt", gnt_h4, exp_gnt(0));
    chk("h4_idx", {2'b00, gnt_idx_h4}, 4'(m_last[0]));
    chk("h4_valid", {3'b000, gnt_valid_h4}, {3'b000, m_owner[0] >= 0});
    chk("h4_valid_or", {3'b000, gnt_valid_h4}, {3'b000, |gnt_h4});
    chk("h0_gnt", gnt_h0, exp_gnt(1));
    chk("h0_idx", {2'b00, gnt_idx_h0}, 4'(m_last[1]));
    chk("h0_valid", {3'b000, gnt_valid_h0}, {3'b000, m_owner[1] >= 0});
    chk("h0_valid_or", {3'b000, gnt_valid_h0}, {3'b000, |gnt_h0});
  endtask

  task automatic tick(input logic [3:0] r4, input logic [3:0] r0);
    req_h4 = r4;
    req_h0 = r0;
    @(posedge clk);
    model_step(0, r4);
    model_step(1, r0);
    #1;
    check_both();
  endtask

  initial begin
    logic [3:0] r4, r0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_both();
    @(negedge clk);
    rst_n = 1'b1;

    // Grab requester 2, then pull reset between edges.
    tick(4'b0100, 4'b0000);
    chk("pre_reset_gnt", gnt_h4, 4'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", gnt_h4, 4'b0000);
    chk("async_rst_idx", {2'b00, gnt_idx_h4}, 4'b0000);
    chk("async_rst_valid", {3'b000, gnt_valid_h4}, 4'b0000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    for (int c = 0; c < 20; c++) begin
      tick(4'b1111, 4'b0000);
      chk("fair_seq", gnt_h4, (c % 5 == 4) ? 4'b0000 : (4'b0001 << ((c / 5) % 4)));
    end

    for (int c = 0; c < 15; c++) begin
      tick(4'b0100, 4'b0000);
      chk("hog_seq", gnt_h4, (c % 5 == 4) ? 4'b0000 : 4'b0100);
    end

    for (int c = 0; c < 3; c++) begin
      tick(4'b0000, 4'b0001);
      chk("single_on", gnt_h0, 4'b0001);
    end
    tick(4'b0000, 4'b0000);
    chk("single_off", gnt_h0, 4'b0000);
    tick(4'b0000, 4'b0011);
    chk("single_ptr", gnt_h0, 4'b0010);
    tick(4'b0000, 4'b0000);

    tick(4'b0000, 4'b0100);
    chk("wrap_own2", gnt_h0, 4'b0100);
    tick(4'b0000, 4'b0100);
    tick(4'b0000, 4'b1001);
    chk("wrap_dead", gnt_h0, 4'b0000);
    tick(4'b0000, 4'b1001);
    chk("wrap_to3", gnt_h0, 4'b1000);
    tick(4'b0000, 4'b0001);
    chk("wrap_dead2", gnt_h0, 4'b0000);
    tick(4'b0000, 4'b0001);
    chk("wrap_to0", gnt_h0, 4'b0001);

    tick(4'b0000, 4'b1000);
    chk("simul_dead", gnt_h0, 4'b0000);
    tick(4'b0000, 4'b1000);
    chk("simul_to3", gnt_h0, 4'b1000);
    tick(4'b0000, 4'b0000);

    r4 = '0;
    r0 = '0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) r4 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r0 = 4'($urandom_range(0, 15));
      tick(r4, r0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
